// File: rtl/hmc_rsp_flit_scheduler.sv
// rtl/hmc_rsp_flit_scheduler.sv - round-robin response packet to FPW-flit PHY word serialiser
module hmc_rsp_flit_scheduler #(
    parameter int FPW       = 4,
    parameter int FLIT_SIZE = 128,
    parameter int DWIDTH    = 512,
    parameter int NUM_REQ   = 2,
    parameter int MAX_LNG   = 9
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic                               link_en,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*MAX_LNG*FLIT_SIZE-1:0] req_data,
    output logic [DWIDTH-1:0]                  phy_data_rx_phy2link,
    output logic                               word_valid,
    output logic [FPW-1:0]                     sop_mask,
    output logic [FPW-1:0]                     eop_mask,
    output logic                               busy,
    output logic                               lng_err
);

    localparam int PKTW  = MAX_LNG * FLIT_SIZE;
    localparam int MAX_W = (MAX_LNG + FPW - 1) / FPW;
    localparam int WCW   = $clog2(MAX_W) + 1;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PKTW-1:0] pkt_buf;
    logic [WCW-1:0]  word_idx;
    logic [WCW-1:0]  words_left;

    logic            grant_point;
    logic            found;
    logic            grant;
    logic [PW-1:0]   grant_idx;
    logic [PKTW-1:0] src_pkt;
    logic [3:0]      src_lng;
    logic            src_lng_ok;
    logic [WCW-1:0]  src_words;
    logic [WCW-1:0]  nxt_idx;
    logic [DWIDTH-1:0] nxt_data;
    logic [FPW-1:0]  nxt_sop;
    logic [FPW-1:0]  nxt_eop;

    // words_left counts the word currently on the output, so 1 means the last word is showing
    assign grant_point = (state == IDLE) || (words_left == WCW'(1));

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        grant = found && grant_point && link_en && res_n;
    end

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[grant_idx] = 1'b1;
    end

    // The granted slice feeds word 0 directly so it appears the cycle after the grant
    assign src_pkt    = grant ? req_data[int'(grant_idx)*PKTW +: PKTW] : pkt_buf;
    assign src_lng    = src_pkt[10:7];
    assign src_lng_ok = (src_lng != 4'd0) && (int'(src_lng) <= MAX_LNG);
    assign src_words  = WCW'((int'(src_lng) + FPW - 1) / FPW);
    assign nxt_idx    = grant ? '0 : word_idx + 1'b1;

    always_comb begin
        nxt_data = '0;
        nxt_sop  = '0;
        nxt_eop  = '0;
        for (int k = 0; k < FPW; k++) begin
            for (int j = 0; j < MAX_LNG; j++) begin
                if ((int'(nxt_idx) * FPW + k == j) && (j < int'(src_lng))) begin
                    nxt_data[k*FLIT_SIZE +: FLIT_SIZE] = src_pkt[j*FLIT_SIZE +: FLIT_SIZE];
                    nxt_sop[k] = (j == 0);
                    nxt_eop[k] = (j == int'(src_lng) - 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            pkt_buf              <= '0;
            word_idx             <= '0;
            words_left           <= '0;
            phy_data_rx_phy2link <= '0;
            word_valid           <= 1'b0;
            sop_mask             <= '0;
            eop_mask             <= '0;
            busy                 <= 1'b0;
            lng_err              <= 1'b0;
        end else begin
            lng_err <= 1'b0;
            if (grant) begin
                rr_ptr  <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                pkt_buf <= src_pkt;
            end
            if (grant && src_lng_ok) begin
                state                <= SEND;
                busy                 <= 1'b1;
                word_idx             <= '0;
                words_left           <= src_words;
                phy_data_rx_phy2link <= nxt_data;
                word_valid           <= 1'b1;
                sop_mask             <= nxt_sop;
                eop_mask             <= nxt_eop;
            end else if (!grant && state == SEND && words_left > WCW'(1)) begin
                word_idx             <= nxt_idx;
                words_left           <= words_left - 1'b1;
                phy_data_rx_phy2link <= nxt_data;
                word_valid           <= 1'b1;
                sop_mask             <= nxt_sop;
                eop_mask             <= nxt_eop;
            end else begin
                // Nothing to send, or an illegal-length packet was swallowed
                lng_err              <= grant;
                state                <= IDLE;
                busy                 <= 1'b0;
                word_idx             <= '0;
                words_left           <= '0;
                phy_data_rx_phy2link <= '0;
                word_valid           <= 1'b0;
                sop_mask             <= '0;
                eop_mask             <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hmc_rsp_flit_scheduler.sv
// tb/tb_hmc_rsp_flit_scheduler.sv - scoreboard bench for hmc_rsp_flit_scheduler
module tb_hmc_rsp_flit_scheduler;

    localparam int FPW   = 4;
    localparam int FLIT  = 128;
    localparam int DW    = 512;
    localparam int NREQ  = 2;
    localparam int MAXL  = 9;
    localparam int PKTW  = MAXL * FLIT;

    typedef struct {
        bit              is_err;
        logic [DW-1:0]   data;
        logic [FPW-1:0]  sop;
        logic [FPW-1:0]  eop;
    } ev_t;

    logic                    clk;
    logic                    res_n;
    logic                    link_en;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*PKTW-1:0]    req_data;
    logic [DW-1:0]           phy_data_rx_phy2link;
    logic                    word_valid;
    logic [FPW-1:0]          sop_mask;
    logic [FPW-1:0]          eop_mask;
    logic                    busy;
    logic                    lng_err;

    int n_checks = 0;
    int n_errors = 0;

    ev_t             exp_ev[$];
    int              exp_grant[$];
    logic [PKTW-1:0] src_q[NREQ][$];

    hmc_rsp_flit_scheduler #(
        .FPW(FPW), .FLIT_SIZE(FLIT), .DWIDTH(DW), .NUM_REQ(NREQ), .MAX_LNG(MAXL)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .link_en(link_en),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .phy_data_rx_phy2link(phy_data_rx_phy2link),
        .word_valid(word_valid),
        .sop_mask(sop_mask),
        .eop_mask(eop_mask),
        .busy(busy),
        .lng_err(lng_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PKTW-1:0] make_pkt(input int lng, input int tag);
        logic [PKTW-1:0] p;
        logic [FLIT-1:0] f;
        logic [7:0]      t8;
        logic [3:0]      l4;
        t8 = 8'(tag);
        l4 = 4'(lng);
        p  = '0;
        for (int j = 0; j < MAXL; j++) begin
            f = {t8, 8'(j), 112'(tag * 4096 + j * 17 + 1)};
            if (j == 0) f[10:7] = l4;
            p[j*FLIT +: FLIT] = f;
        end
        return p;
    endfunction

    // Queue the packet at its source and record the grant and words it must produce
    task automatic issue(input int src, input int lng, input int tag);
        logic [PKTW-1:0] p;
        ev_t e;
        p = make_pkt(lng, tag);
        src_q[src].push_back(p);
        exp_grant.push_back(src);
        if (lng < 1 || lng > MAXL) begin
            e.is_err = 1'b1; e.data = '0; e.sop = '0; e.eop = '0;
            exp_ev.push_back(e);
        end else begin
            for (int w = 0; w < (lng + FPW - 1) / FPW; w++) begin
                e.is_err = 1'b0; e.data = '0; e.sop = '0; e.eop = '0;
                for (int k = 0; k < FPW; k++) begin
                    if (w * FPW + k < lng) e.data[k*FLIT +: FLIT] = p[(w*FPW+k)*FLIT +: FLIT];
                    if (w * FPW + k == 0) e.sop[k] = 1'b1;
                    if (w * FPW + k == lng - 1) e.eop[k] = 1'b1;
                end
                exp_ev.push_back(e);
            end
        end
    endtask

    task automatic drive_src(input int s);
        bit hs;
        hs = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hs) req_valid[s] = 1'b0;
            if (!req_valid[s] && src_q[s].size() != 0) begin
                req_data[s*PKTW +: PKTW] = src_q[s].pop_front();
                req_valid[s] = 1'b1;
            end
            @(negedge clk);
            hs = req_valid[s] && req_ready[s] && res_n;
        end
    endtask

    initial drive_src(0);
    initial drive_src(1);

    ev_t mon_e;
    int  mon_g;
    always @(negedge clk) begin
        if (res_n) begin
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) chk("unexpected_grant", DW'(req_ready), '0);
                else begin
                    mon_g = exp_grant.pop_front();
                    chk("grant_onehot", DW'(req_ready), DW'(1) << mon_g);
                end
            end
            if (word_valid || lng_err) begin
                if (exp_ev.size() == 0) chk("unexpected_output", DW'({word_valid, lng_err}), '0);
                else begin
                    mon_e = exp_ev.pop_front();
                    chk("lng_err", DW'(lng_err), DW'(mon_e.is_err));
                    chk("word_valid", DW'(word_valid), DW'(!mon_e.is_err));
                    if (!mon_e.is_err) begin
                        chk("word_data", phy_data_rx_phy2link, mon_e.data);
                        chk("sop_mask", DW'(sop_mask), DW'(mon_e.sop));
                        chk("eop_mask", DW'(eop_mask), DW'(mon_e.eop));
                    end
                end
            end
        end
    end

    task automatic window(input int n, output int wv, output int bz, output int er,
                          output int rdy, output bit contig);
        int first, last;
        first = -1; last = -1; wv = 0; bz = 0; er = 0; rdy = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (word_valid) begin
                wv++;
                if (first < 0) first = c;
                last = c;
            end
            if (busy) bz++;
            if (lng_err) er++;
            if (req_ready != '0) rdy++;
        end
        contig = (wv == 0) || (last - first + 1 == wv);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_data"}, phy_data_rx_phy2link, '0);
        chk({tag, "_flags"}, DW'({word_valid, busy, lng_err, sop_mask, eop_mask, req_ready}), '0);
    endtask

    int wv, bz, er, rdy;
    bit contig;
    bit seen;

    initial begin
        res_n = 1'b0; link_en = 1'b0; req_valid = '0; req_data = '0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1; res_n = 1'b1; link_en = 1'b1;
        @(negedge clk);

        issue(0, 1, 1);
        window(8, wv, bz, er, rdy, contig);
        chk("lng1_words", DW'(wv), DW'(1)); chk("lng1_busy", DW'(bz), DW'(1));

        issue(1, 4, 2);
        window(8, wv, bz, er, rdy, contig);
        chk("lng4_words", DW'(wv), DW'(1)); chk("lng4_busy", DW'(bz), DW'(1));

        issue(0, 5, 3);
        window(8, wv, bz, er, rdy, contig);
        chk("lng5_words", DW'(wv), DW'(2)); chk("lng5_busy", DW'(bz), DW'(2));
        chk("lng5_contig", DW'(contig), DW'(1));

        issue(1, 10, 4);
        window(8, wv, bz, er, rdy, contig);
        chk("lng10_words", DW'(wv), '0); chk("lng10_err", DW'(er), DW'(1));

        issue(1, 0, 5);
        window(8, wv, bz, er, rdy, contig);
        chk("lng0_words", DW'(wv), '0); chk("lng0_err", DW'(er), DW'(1));
        chk("lng0_busy", DW'(bz), '0);

        // Both sources busy: rr pointer is back at 0, so grants go 0,1,0,1
        issue(0, 9, 6); issue(1, 2, 7); issue(0, 9, 8); issue(1, 2, 9);
        window(20, wv, bz, er, rdy, contig);
        chk("b2b_words", DW'(wv), DW'(8)); chk("b2b_contig", DW'(contig), DW'(1));
        chk("b2b_grants", DW'(rdy), DW'(4));

        issue(0, 9, 10);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = word_valid;
        end
        chk("rst_wait_word0", DW'(seen), DW'(1));
        @(posedge clk); #1;
        res_n = 1'b0;
        #1;
        check_zero_outputs("midpkt_reset");
        exp_ev.delete();
        link_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        res_n = 1'b1;
        @(negedge clk);

        issue(0, 1, 11); issue(1, 2, 12);
        window(5, wv, bz, er, rdy, contig);
        chk("linkoff_ready", DW'(rdy), '0); chk("linkoff_words", DW'(wv), '0);
        chk("linkoff_busy", DW'(bz), '0);
        @(posedge clk); #1;
        link_en = 1'b1;
        window(10, wv, bz, er, rdy, contig);
        chk("linkon_words", DW'(wv), DW'(2)); chk("linkon_contig", DW'(contig), DW'(1));

        chk("left_events", DW'(exp_ev.size()), '0);
        chk("left_grants", DW'(exp_grant.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
